// File: rtl/psg_bus_master.sv
// PSG BDIR/BC bus initiator: turns single register read/write requests into
// the latch-address / gap / data / gap phase sequence, skipping the address
// latch when the request targets the register latched last time.
module psg_bus_master #(
    parameter int unsigned PHASE_LEN = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic       addr_inval,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       BDIR,
    output logic       BC,
    output logic [7:0] BUS_DO,
    input  logic [7:0] BUS_DI
);

    localparam logic [7:0] LastCnt = 8'(PHASE_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StGap1,
        StWr,
        StRd,
        StGap2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    // Latched request, held for the whole sequence
    logic       wr_q, wr_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;

    // Address cache
    logic       cache_valid_q, cache_valid_d;
    logic [3:0] cache_addr_q, cache_addr_d;

    // Response path
    logic [7:0] rd_cap_q, rd_cap_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;

    // Registered bus outputs
    logic       bdir_q, bdir_d;
    logic       bc_q, bc_d;
    logic [7:0] bus_do_q, bus_do_d;

    logic accept;
    logic hit;
    logic phase_last;

    assign req_ready  = (state_q == StIdle);
    assign busy       = ~req_ready;
    assign accept     = req_valid & req_ready;
    // An invalidate on the accept cycle forces the miss path
    assign hit        = cache_valid_q & ~addr_inval & (cache_addr_q == req_addr);
    assign phase_last = (cnt_q == LastCnt);

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign BDIR      = bdir_q;
    assign BC        = bc_q;
    assign BUS_DO    = bus_do_q;

    // State register and phase counter
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: every non-idle phase lasts PHASE_LEN cycles
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (hit) begin
                        state_d = req_write ? StWr : StRd;
                    end else begin
                        state_d = StAddr;
                    end
                end
            end
            StAddr: if (phase_last) state_d = StGap1;
            StGap1: if (phase_last) state_d = wr_q ? StWr : StRd;
            StWr:   if (phase_last) state_d = StGap2;
            StRd:   if (phase_last) state_d = StGap2;
            StGap2: if (phase_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        cnt_d = (state_q == StIdle || phase_last) ? 8'd0 : cnt_q + 8'd1;
    end

    // Output logic: bus values follow the state being entered so the
    // registered pins change together with the state
    always_comb begin
        wr_d    = accept ? req_write : wr_q;
        addr_d  = accept ? req_addr  : addr_q;
        wdata_d = accept ? req_wdata : wdata_q;

        bdir_d   = 1'b0;
        bc_d     = 1'b0;
        bus_do_d = 8'h00;
        unique case (state_d)
            StAddr: begin
                bdir_d   = 1'b1;
                bc_d     = 1'b1;
                bus_do_d = {4'h0, addr_d};
            end
            StWr: begin
                bdir_d   = 1'b1;
                bus_do_d = wdata_d;
            end
            StRd: begin
                bc_d = 1'b1;
            end
            default: begin
                bdir_d   = 1'b0;
                bc_d     = 1'b0;
                bus_do_d = 8'h00;
            end
        endcase

        rd_cap_d    = (state_q == StRd && phase_last) ? BUS_DI : rd_cap_q;
        rsp_valid_d = (state_q == StGap2) && phase_last;
        rsp_rdata_d = (rsp_valid_d && !wr_q) ? rd_cap_q : rsp_rdata_q;

        cache_valid_d = cache_valid_q;
        cache_addr_d  = cache_addr_q;
        if (state_q == StAddr && phase_last) begin
            cache_valid_d = 1'b1;
            cache_addr_d  = addr_q;
        end
        // Invalidate wins over a simultaneous set
        if (addr_inval) begin
            cache_valid_d = 1'b0;
        end
    end

    // Datapath, cache and registered outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_q          <= 1'b0;
            addr_q        <= 4'h0;
            wdata_q       <= 8'h00;
            cache_valid_q <= 1'b0;
            cache_addr_q  <= 4'h0;
            rd_cap_q      <= 8'hFF;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 8'hFF;
            bdir_q        <= 1'b0;
            bc_q          <= 1'b0;
            bus_do_q      <= 8'h00;
        end else begin
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cache_valid_q <= cache_valid_d;
            cache_addr_q  <= cache_addr_d;
            rd_cap_q      <= rd_cap_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            bdir_q        <= bdir_d;
            bc_q          <= bc_d;
            bus_do_q      <= bus_do_d;
        end
    end

endmodule

// File: tb/tb_psg_bus_master.sv
// Bench for psg_bus_master: directed requests against a small PSG register
// model, with a scoreboard checking response latency and read data.
module tb_psg_bus_master;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [3:0] req_addr = 4'h0;
    logic [7:0] req_wdata = 8'h00;
    logic       addr_inval = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       BDIR;
    logic       BC;
    logic [7:0] BUS_DO;
    logic [7:0] BUS_DI;

    psg_bus_master #(.PHASE_LEN(2)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .addr_inval (addr_inval),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .busy       (busy),
        .BDIR       (BDIR),
        .BC         (BC),
        .BUS_DO     (BUS_DO),
        .BUS_DI     (BUS_DI)
    );

    always #5 CLK = ~CLK;

    // PSG register model
    logic [7:0] regs [16];
    logic [3:0] maddr = 4'h0;
    assign BUS_DI = regs[maddr];
    always @(posedge CLK) begin
        if (BDIR && BC) maddr <= BUS_DO[3:0];
        else if (BDIR && !BC) regs[maddr] <= BUS_DO;
    end

    typedef struct {
        int         lat;
        logic [7:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   checks = 0;
    int   failures = 0;
    int   ncyc = 0;
    int   coinc = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: records accepts, pops and compares on every response
    always @(negedge CLK) begin
        ncyc++;
        if (RESET) begin
            acc_q.delete();
        end else begin
            if (rsp_valid) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    int   a;
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("rsp_latency", 32'(ncyc - a), 32'(e.lat));
                    chk("rsp_rdata", {24'h0, rsp_rdata}, {24'h0, e.rdata});
                end
            end
            if (req_valid && req_ready) begin
                acc_q.push_back(ncyc);
                if (rsp_valid) coinc++;
            end
        end
    end

    // Present a request and return in its accept cycle (req_valid still high)
    task automatic issue(input logic w, input logic [3:0] a, input logic [7:0] d,
                         input logic inval, input int lat, input logic [7:0] rd,
                         input logic push);
        exp_t e;
        @(posedge CLK);
        #2;
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        addr_inval = inval;
        if (push) begin
            e.lat   = lat;
            e.rdata = rd;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (req_ready) return;
        end
        chk("accept_timeout", 32'd1, 32'd0);
    endtask

    task automatic release_req();
        @(posedge CLK);
        #2;
        req_valid  = 1'b0;
        addr_inval = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (exp_q.size() == 0) return;
        end
        chk("rsp_timeout", 32'd1, 32'd0);
        exp_q.delete();
    endtask

    task automatic chk_bus(input string name, input logic bd, input logic bc,
                           input logic [7:0] d);
        chk(name, {22'h0, BDIR, BC, BUS_DO}, {22'h0, bd, bc, d});
    endtask

    logic [9:0] t1_bus [8];
    int         c0;
    logic       saw_wr;

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        t1_bus = '{{2'b11, 8'h07}, {2'b11, 8'h07}, {2'b00, 8'h00}, {2'b00, 8'h00},
                   {2'b10, 8'h38}, {2'b10, 8'h38}, {2'b00, 8'h00}, {2'b00, 8'h00}};

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        chk_bus("reset_bus", 1'b0, 1'b0, 8'h00);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", {24'h0, rsp_rdata}, 32'h0000_00FF);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("reset_ready", {30'h0, req_ready, busy}, 32'd2);

        // 1: write reg7 = 38, miss path, full bus trace
        issue(1'b1, 4'd7, 8'h38, 1'b0, 9, 8'hFF, 1'b1);
        release_req();
        for (int n = 0; n < 8; n++) begin
            @(negedge CLK);
            chk($sformatf("t1_bus_c%0d", n + 1), {22'h0, BDIR, BC, BUS_DO}, {22'h0, t1_bus[n]});
        end
        wait_done();
        chk("t1_reg7", {24'h0, regs[7]}, 32'h38);

        // 2: same-address write, hit path
        issue(1'b1, 4'd7, 8'h3F, 1'b0, 5, 8'hFF, 1'b1);
        release_req();
        @(negedge CLK) chk_bus("t2_wr_c1", 1'b1, 1'b0, 8'h3F);
        @(negedge CLK) chk_bus("t2_wr_c2", 1'b1, 1'b0, 8'h3F);
        @(negedge CLK) chk_bus("t2_gap_c3", 1'b0, 1'b0, 8'h00);
        wait_done();
        chk("t2_reg7", {24'h0, regs[7]}, 32'h3F);

        // 3: read reg8, then a write leaves rsp_rdata alone
        regs[8] = 8'h0F;
        issue(1'b0, 4'd8, 8'h00, 1'b0, 9, 8'h0F, 1'b1);
        release_req();
        @(negedge CLK) chk_bus("t3_addr_c1", 1'b1, 1'b1, 8'h08);
        repeat (4) @(negedge CLK);
        chk_bus("t3_rd_c5", 1'b0, 1'b1, 8'h00);
        @(negedge CLK) chk_bus("t3_rd_c6", 1'b0, 1'b1, 8'h00);
        wait_done();
        issue(1'b1, 4'd8, 8'h5A, 1'b0, 5, 8'h0F, 1'b1);
        release_req();
        wait_done();

        // 4: invalidate while idle, then invalidate on the accept cycle
        @(posedge CLK);
        #2 addr_inval = 1'b1;
        @(posedge CLK);
        #2 addr_inval = 1'b0;
        issue(1'b1, 4'd8, 8'h10, 1'b0, 9, 8'h0F, 1'b1);
        release_req();
        wait_done();
        issue(1'b1, 4'd8, 8'h11, 1'b1, 9, 8'h0F, 1'b1);
        release_req();
        wait_done();
        issue(1'b1, 4'd8, 8'h12, 1'b0, 5, 8'h0F, 1'b1);
        release_req();
        wait_done();
        chk("t4_reg8", {24'h0, regs[8]}, 32'h12);

        // 5: req_valid held across back-to-back requests
        c0 = coinc;
        issue(1'b1, 4'd9, 8'hA1, 1'b0, 9, 8'h0F, 1'b1);
        issue(1'b1, 4'd9, 8'hA2, 1'b0, 5, 8'h0F, 1'b1);
        issue(1'b0, 4'd9, 8'h00, 1'b0, 5, 8'hA2, 1'b1);
        release_req();
        wait_done();
        repeat (3) @(negedge CLK);
        chk("t5_coincident_accepts", 32'(coinc - c0), 32'd2);
        chk("t5_reg9", {24'h0, regs[9]}, 32'hA2);

        // 6: reset during the WR phase aborts without a response
        issue(1'b1, 4'd5, 8'h55, 1'b0, 9, 8'h00, 1'b0);
        release_req();
        saw_wr = 1'b0;
        for (int i = 0; i < 20 && !saw_wr; i++) begin
            @(negedge CLK);
            if (BDIR && !BC) saw_wr = 1'b1;
        end
        chk("t6_saw_wr", {31'h0, saw_wr}, 32'd1);
        @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk_bus("t6_reset_bus", 1'b0, 1'b0, 8'h00);
        chk("t6_reset_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        @(posedge CLK);
        #2 RESET = 1'b0;
        repeat (6) @(negedge CLK);
        chk("t6_rdata_after_reset", {24'h0, rsp_rdata}, 32'h0000_00FF);
        issue(1'b1, 4'd5, 8'h66, 1'b0, 9, 8'hFF, 1'b1);
        release_req();
        @(negedge CLK) chk_bus("t6_addr_again", 1'b1, 1'b1, 8'h05);
        wait_done();
        chk("t6_reg5", {24'h0, regs[5]}, 32'h66);

        repeat (4) @(negedge CLK);
        chk("sb_pending", 32'(exp_q.size() + acc_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench always ends
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/psg_bus_master.md
Name: psg_bus_master

Overview:
- Host-side initiator for the PSG's BDIR/BC bus.
- Turns single register read/write requests into the chip's latch-address, inactive, write-value or read-value, inactive phase sequence.
- Sits between the CPU/PPI glue and the PSG instance, so higher-level logic never drives BDIR/BC directly.
- Caches the last latched address and skips the latch phase when a request targets the same register.

Parameters:
PHASE_LEN, 2, CLK cycles each bus phase (address, gap, data, gap) is held; legal range 1..255

Ports:
CLK  in  1  global clock
RESET  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_write  in  1  1 = register write, 0 = register read
req_addr  in  4  PSG register number 0..15
req_wdata  in  8  write data
addr_inval  in  1  forget the cached latched address
rsp_valid  out  1  one-cycle pulse: request completed
rsp_rdata  out  8  read data; updated only by reads
busy  out  1  sequence in progress (= ~req_ready)
BDIR  out  1  PSG bus direction
BC  out  1  PSG bus control
BUS_DO  out  8  data/address driven to PSG DI
BUS_DI  in  8  PSG DO

Behaviour:
- Reset (async, immediate):
  - State IDLE; BDIR=0, BC=0, BUS_DO=8'h00.
  - rsp_valid=0, rsp_rdata=8'hFF.
  - Cache invalid; phase counter 0; req_ready=1 once RESET deasserts.
- All PSG-side outputs and rsp_* are registered. req_ready = (state==IDLE), combinational from state.
- Accept on req_valid & req_ready (cycle 0). Latch req_write, req_addr and req_wdata internally; later input changes are ignored.
- States and bus encoding:
  - IDLE: BDIR=0, BC=0.
  - ADDR: BDIR=1, BC=1, BUS_DO={4'h0, addr}.
  - GAP1: 0/0.
  - WR: BDIR=1, BC=0, BUS_DO=wdata.
  - RD: BDIR=0, BC=1.
  - GAP2: 0/0.
  - BUS_DO=8'h00 in every state except ADDR and WR.
- Transitions:
  - Each non-IDLE state lasts exactly PHASE_LEN cycles, counted by the phase counter.
  - IDLE -> ADDR if the cache is invalid or the cached address differs from req_addr.
  - Otherwise IDLE -> WR or RD directly, skipping ADDR and GAP1.
  - ADDR -> GAP1 -> WR/RD -> GAP2 -> IDLE.
- Latency, taking acceptance as cycle 0:
  - Cache miss: bus phases occupy cycles 1..4P; rsp_valid=1 and req_ready=1 in cycle 4P+1.
  - Cache hit: phases occupy 1..2P; rsp_valid in cycle 2P+1.
  - A new request may be accepted in the same cycle rsp_valid is high.
- Read capture: BUS_DI is sampled on the last CLK of RD and presented on rsp_rdata with rsp_valid. rsp_rdata then holds until the next read completes.
- Cache:
  - On the last cycle of ADDR, cached address := addr and cache becomes valid.
  - addr_inval clears valid in any cycle. If addr_inval coincides with the ADDR-completion set, clear wins.
  - If addr_inval coincides with request acceptance, the request takes the miss path.
  - An in-flight sequence is never aborted by addr_inval.
- Back-pressure: while busy, req_valid is ignored and no request is queued. The requester must hold req_valid until it sees req_ready.
- Overlap rules:
  - BDIR and BC are never both 1 outside ADDR.
  - Every WR or RD phase is preceded (when ADDR was used) and followed by at least PHASE_LEN cycles of 0/0.
- Reset mid-operation: BDIR/BC drop to 0 immediately, no rsp_valid is issued for the aborted request, and the cache is invalid.
- PHASE_LEN=1 is legal; each phase is then one cycle: miss=4, hit=2 cycles of bus activity.

Test Plan:
1. PHASE_LEN=2, after reset, write reg 7=8'h38 -> cycles 1-2 BDIR/BC=1/1 with BUS_DO=8'h07; 3-4 0/0; 5-6 1/0 with BUS_DO=8'h38; 7-8 0/0; rsp_valid pulse in cycle 9; PSG model reg7==8'h38.
2. Write reg 7=8'h3F immediately after test 1 -> no ADDR phase; WR in cycles 1-2; rsp_valid in cycle 5; reg7==8'h3F.
3. PSG model reg 8=8'h0F, read reg 8 -> ADDR BUS_DO=8'h08 then RD (0/1) in cycles 5-6; rsp_rdata=8'h0F with rsp_valid in cycle 9; a following write leaves rsp_rdata at 8'h0F.
4. Pulse addr_inval, then write reg 8=8'h10 -> ADDR phase present again (miss timing, rsp_valid at cycle 9). Also assert addr_inval on the accept cycle of a same-address request -> miss path taken.
5. Hold req_valid continuously with two queued values -> req_ready low through the whole sequence; second accept occurs exactly in the rsp_valid cycle; no request is dropped or duplicated.
6. Assert RESET during the WR phase -> same-cycle BDIR=BC=0 and BUS_DO=8'h00; no rsp_valid; after release, a same-address write takes the full miss path.
